// File: rtl/dac_pkg.sv
// Shared definitions for the MCP4921-class DAC write path.
// Holds the command-frame layout, the FSM state type, the per-state phase
// counts and a helper that assembles the 16-bit command frame.
package dac_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DATA_W  = 12;

  // Config bit positions inside the command frame.
  localparam int unsigned CH_BIT   = 15;
  localparam int unsigned BUF_BIT  = 14;
  localparam int unsigned GA_BIT   = 13;
  localparam int unsigned SHDN_BIT = 12;

  // Number of CLK_DIV-long phases spent in each state.
  localparam int unsigned SETUP_PHASES = 1;
  localparam int unsigned SHIFT_PHASES = 32;
  localparam int unsigned LDAC_PHASES  = 1;
  localparam int unsigned GAP_PHASES   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StLdac,
    StGap
  } dac_state_e;

  // Channel A is always selected (bit 15 = 0).
  function automatic logic [FRAME_W-1:0] build_frame(input logic              buf_bit,
                                                     input logic              ga_n,
                                                     input logic              shdn_n,
                                                     input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f           = '0;
    f[CH_BIT]   = 1'b0;
    f[BUF_BIT]  = buf_bit;
    f[GA_BIT]   = ga_n;
    f[SHDN_BIT] = shdn_n;
    f[DATA_W-1:0] = data;
    return f;
  endfunction

endpackage

// File: rtl/dac_write_phase_tick.sv
// Phase timer for the DAC write FSM.
// A CLK_DIV down-counter that marks the last cycle of every phase.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-high reset
//   clear_i     - hold the counter at the start of a phase
//   tick_o      - high on the last cycle of the current phase
//   tick_next_o - tick_o value for the next cycle (lets the parent register
//                 outputs that must line up with the final cycle of a phase)
module dac_phase_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o,
  output logic tick_next_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == '0)) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  assign tick_o      = (cnt_q == '0);
  assign tick_next_o = (cnt_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_write.sv
// SPI write master for a 12-bit serial DAC (MCP4921-class, 16-bit frame).
// Accepts a sample over valid/ready, shifts {0, BUF, GA_N, SHDN_N, sample}
// MSB-first in SPI mode 0, then pulses LDAC_n. All pins are registered.
// Ports:
//   clk          - 50 MHz system clock
//   rst          - asynchronous active-high reset
//   sample       - 12-bit data word, captured on the accept edge
//   sample_valid - producer has a sample
//   sample_ready - block can accept a sample this cycle
//   frame_done   - one-cycle pulse on the final cycle of a frame
//   dac_cs_n     - chip select, active low
//   dac_sck      - serial clock, idles low
//   dac_sdi      - serial data to the DAC
//   dac_ldac_n   - latch DAC output, active low
module dac_write
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter logic        BUF     = 1'b0,
  parameter logic        GA_N    = 1'b1,
  parameter logic        SHDN_N  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_done,
  output logic              dac_cs_n,
  output logic              dac_sck,
  output logic              dac_sdi,
  output logic              dac_ldac_n
);

  localparam logic [4:0] NumBits = 5'(SHIFT_PHASES / 2);

  dac_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [4:0]         bit_q, bit_d;
  logic               hi_q, hi_d;

  logic ready_q, ready_d;
  logic done_q, done_d;
  logic cs_n_q, cs_n_d;
  logic sck_q, sck_d;
  logic sdi_q, sdi_d;
  logic ldac_n_q, ldac_n_d;

  logic tick, tick_next, accept;

  dac_phase_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_tick (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == StIdle),
    .tick_o     (tick),
    .tick_next_o(tick_next)
  );

  assign accept = sample_valid && ready_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          shreg_d = build_frame(BUF, GA_N, SHDN_N, sample);
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StShift;
          hi_d    = 1'b1;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (tick) begin
          if (hi_q) begin
            // Falling SCK edge: present the next bit for the following rise.
            hi_d    = 1'b0;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            bit_d   = bit_q + 5'd1;
          end else if (bit_q == NumBits) begin
            state_d = StLdac;
          end else begin
            hi_d = 1'b1;
          end
        end
      end
      StLdac: begin
        if (tick) begin
          state_d = StGap;
        end
      end
      StGap: begin
        // ready is already high on this final cycle, so a waiting producer
        // starts the next frame with no idle cycle in between.
        if (tick) begin
          if (accept) begin
            state_d = StSetup;
            shreg_d = build_frame(BUF, GA_N, SHDN_N, sample);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin values are derived from the next state so they change on the same
  // edge as the FSM and come straight out of flops.
  always_comb begin
    cs_n_d   = !((state_d == StSetup) || (state_d == StShift));
    sck_d    = (state_d == StShift) && hi_d;
    sdi_d    = ((state_d == StSetup) || (state_d == StShift)) ? shreg_d[FRAME_W-1] : 1'b0;
    ldac_n_d = (state_d != StLdac);
    done_d   = (state_d == StGap) && tick_next;
    ready_d  = (state_d == StIdle) || ((state_d == StGap) && tick_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bit_q    <= '0;
      hi_q     <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      ldac_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      hi_q     <= hi_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      ldac_n_q <= ldac_n_d;
    end
  end

  assign sample_ready = ready_q;
  assign frame_done   = done_q;
  assign dac_cs_n     = cs_n_q;
  assign dac_sck      = sck_q;
  assign dac_sdi      = sdi_q;
  assign dac_ldac_n   = ldac_n_q;

endmodule

// File: tb/tb_dac_write.sv
// Directed bench for dac_write. Three instances share clk/rst:
//   0: CLK_DIV=2 defaults, 1: CLK_DIV=1, 2: CLK_DIV=5 (both BUF=1, GA_N=0, SHDN_N=0).
// sel picks which instance receives sample_valid and is observed.
module tb_dac_write;

  logic        clk;
  logic        rst;
  logic [11:0] sample;
  logic        valid;
  logic [1:0]  sel;

  logic [2:0] valid_w, ready_w, done_w, cs_n_w, sck_w, sdi_w, ldac_n_w;
  logic       m_ready, m_done, m_cs_n, m_sck, m_sdi, m_ldac_n;

  int checks;
  int failures;

  // Results of the most recent capture().
  logic [15:0] cap_frame;
  int cap_rises, cap_cs_low, cap_ldac_low, cap_done_cnt, cap_done_cyc, cap_busy;
  bit cap_ldac_aligned, cap_timeout;

  assign valid_w[0] = valid && (sel == 2'd0);
  assign valid_w[1] = valid && (sel == 2'd1);
  assign valid_w[2] = valid && (sel == 2'd2);

  always_comb begin
    m_ready  = ready_w[sel];
    m_done   = done_w[sel];
    m_cs_n   = cs_n_w[sel];
    m_sck    = sck_w[sel];
    m_sdi    = sdi_w[sel];
    m_ldac_n = ldac_n_w[sel];
  end

  dac_write #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(valid_w[0]),
    .sample_ready(ready_w[0]), .frame_done(done_w[0]), .dac_cs_n(cs_n_w[0]),
    .dac_sck(sck_w[0]), .dac_sdi(sdi_w[0]), .dac_ldac_n(ldac_n_w[0])
  );

  dac_write #(.CLK_DIV(1), .BUF(1'b1), .GA_N(1'b0), .SHDN_N(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(valid_w[1]),
    .sample_ready(ready_w[1]), .frame_done(done_w[1]), .dac_cs_n(cs_n_w[1]),
    .dac_sck(sck_w[1]), .dac_sdi(sdi_w[1]), .dac_ldac_n(ldac_n_w[1])
  );

  dac_write #(.CLK_DIV(5), .BUF(1'b1), .GA_N(1'b0), .SHDN_N(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(valid_w[2]),
    .sample_ready(ready_w[2]), .frame_done(done_w[2]), .dac_cs_n(cs_n_w[2]),
    .dac_sck(sck_w[2]), .dac_sdi(sdi_w[2]), .dac_ldac_n(ldac_n_w[2])
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Wait at a negedge for ready on instance idx, then present s; returns
  // just after the accept posedge with valid still high.
  task automatic send(input logic [11:0] s, input logic [1:0] idx);
    bit got;
    got   = 0;
    valid = 1'b0;
    sel   = idx;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (m_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_ready_wait: ready=%0b required 1 within 300 cycles", m_ready);
    end
    sample = s;
    valid  = 1'b1;
    @(posedge clk);
  endtask

  // Observe one frame starting right after an accept edge; ends at the first
  // negedge where ready is high again. cyc counts cycles after the accept edge.
  task automatic capture(input bit noise, input bit c1_valid, input logic [11:0] c1_sample);
    logic prev_sck;
    int   cs_rise_cyc, ldac_first;
    bit   got;
    prev_sck = 1'b0;
    cs_rise_cyc = -1;
    ldac_first  = -1;
    got = 0;
    cap_frame = '0;
    cap_rises = 0;
    cap_cs_low = 0;
    cap_ldac_low = 0;
    cap_done_cnt = 0;
    cap_done_cyc = -1;
    cap_busy = 0;
    cap_timeout = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (m_sck && !prev_sck) begin
        cap_frame = {cap_frame[14:0], m_sdi};
        cap_rises++;
      end
      prev_sck = m_sck;
      if (!m_cs_n) cap_cs_low++;
      else if (cs_rise_cyc < 0) cs_rise_cyc = cyc;
      if (!m_ldac_n) begin
        cap_ldac_low++;
        if (ldac_first < 0) ldac_first = cyc;
      end
      if (m_done) begin
        cap_done_cnt++;
        cap_done_cyc = cyc;
      end
      if (cyc == 1) begin
        valid  = c1_valid;
        sample = c1_sample;
      end
      if (noise) begin
        if (!m_ready) begin
          valid  = 1'($urandom_range(0, 1));
          sample = 12'($urandom);
        end else begin
          valid = 1'b0;
        end
      end
      if (m_ready) begin
        cap_busy = cyc;
        got = 1;
        break;
      end
    end
    cap_timeout = !got;
    cap_ldac_aligned = (ldac_first > 0) && (ldac_first == cs_rise_cyc);
  endtask

  task automatic test_reset;
    int rises, sck_hi, cs_lo;
    logic prev;
    sel   = 2'd0;
    valid = 1'b0;
    sample = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_ready, m_done, m_cs_n, m_sck, m_sdi, m_ldac_n} !== 6'b001001) begin
      failures++;
      $display("FAIL reset_state: pins=%b required 001001",
               {m_ready, m_done, m_cs_n, m_sck, m_sdi, m_ldac_n});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: ready=%b required 1", m_ready);
    end
    // Abort a frame at its 10th SCK rising edge.
    send(12'hFFF, 2'd0);
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 200 && rises < 10; n++) begin
      @(negedge clk);
      valid = 1'b0;
      if (m_sck && !prev) rises++;
      prev = m_sck;
    end
    checks++;
    if (rises != 10) begin
      failures++;
      $display("FAIL reset_reach_edge10: rises=%0d required 10", rises);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_ready, m_done, m_cs_n, m_sck, m_sdi, m_ldac_n} !== 6'b001001) begin
      failures++;
      $display("FAIL reset_midframe: pins=%b required 001001",
               {m_ready, m_done, m_cs_n, m_sck, m_sdi, m_ldac_n});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_midframe_ready: ready=%b required 1", m_ready);
    end
    sck_hi = 0;
    cs_lo  = 0;
    repeat (80) begin
      @(negedge clk);
      if (m_sck) sck_hi++;
      if (!m_cs_n) cs_lo++;
    end
    checks++;
    if (sck_hi != 0 || cs_lo != 0) begin
      failures++;
      $display("FAIL reset_quiet: sck_high=%0d cs_low=%0d required 0 0", sck_hi, cs_lo);
    end
  endtask

  task automatic test_single_frame;
    send(12'hA5C, 2'd0);
    capture(0, 1'b0, 12'h000);
    checks++;
    if (cap_timeout) begin
      failures++;
      $display("FAIL single_timeout: ready never returned");
    end
    checks++;
    if (cap_frame !== 16'h3A5C) begin
      failures++;
      $display("FAIL single_frame: got=%h required 3a5c", cap_frame);
    end
    checks++;
    if (cap_cs_low != 66 || cap_rises != 16) begin
      failures++;
      $display("FAIL single_timing: cs_low=%0d rises=%0d required 66 16", cap_cs_low, cap_rises);
    end
  endtask

  task automatic test_ldac_done;
    send(12'hA5C, 2'd0);
    capture(0, 1'b0, 12'h000);
    checks++;
    if (cap_ldac_low != 2 || !cap_ldac_aligned) begin
      failures++;
      $display("FAIL ldac_pulse: low=%0d aligned=%0b required 2 1", cap_ldac_low,
               cap_ldac_aligned);
    end
    checks++;
    if (cap_done_cnt != 1 || cap_done_cyc != 70) begin
      failures++;
      $display("FAIL frame_done: count=%0d cycle=%0d required 1 70", cap_done_cnt,
               cap_done_cyc);
    end
  endtask

  task automatic test_back_to_back;
    send(12'h000, 2'd0);
    capture(0, 1'b1, 12'hFFF);
    checks++;
    if (cap_frame !== 16'h3000 || cap_busy != 70) begin
      failures++;
      $display("FAIL b2b_first: frame=%h next_accept=%0d required 3000 70", cap_frame, cap_busy);
    end
    // valid is still high here, so the next posedge is the second accept.
    @(posedge clk);
    capture(0, 1'b0, 12'h000);
    checks++;
    if (cap_frame !== 16'h3FFF || cap_rises != 16) begin
      failures++;
      $display("FAIL b2b_second: frame=%h rises=%0d required 3fff 16", cap_frame, cap_rises);
    end
  endtask

  task automatic test_busy_isolation;
    int cs_lo;
    send(12'h5A3, 2'd0);
    capture(1, 1'b0, 12'h000);
    checks++;
    if (cap_frame !== 16'h35A3 || cap_rises != 16 || cap_cs_low != 66 || cap_done_cnt != 1) begin
      failures++;
      $display("FAIL busy_frame: frame=%h rises=%0d cs_low=%0d done=%0d required 35a3 16 66 1",
               cap_frame, cap_rises, cap_cs_low, cap_done_cnt);
    end
    cs_lo = 0;
    repeat (20) begin
      @(negedge clk);
      if (!m_cs_n) cs_lo++;
    end
    checks++;
    if (cs_lo != 0) begin
      failures++;
      $display("FAIL busy_no_extra_accept: cs_low=%0d required 0", cs_lo);
    end
  endtask

  task automatic test_param_sweep;
    int div;
    for (int k = 1; k <= 2; k++) begin
      div = (k == 1) ? 1 : 5;
      send(12'h123, 2'(k));
      capture(0, 1'b0, 12'h000);
      checks++;
      if (cap_frame !== 16'h4123 || cap_rises != 16) begin
        failures++;
        $display("FAIL sweep_frame_div%0d: frame=%h rises=%0d required 4123 16", div, cap_frame,
                 cap_rises);
      end
      checks++;
      if (cap_cs_low != 33 * div || cap_busy != 35 * div) begin
        failures++;
        $display("FAIL sweep_timing_div%0d: cs_low=%0d busy=%0d required %0d %0d", div,
                 cap_cs_low, cap_busy, 33 * div, 35 * div);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst    = 1'b1;
    valid  = 1'b0;
    sample = '0;
    sel    = 2'd0;
    test_reset();
    test_single_frame();
    test_ldac_done();
    test_back_to_back();
    test_busy_isolation();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
